alu_req_arbiter: RTL and testbench
==================================

Name: alu_req_arbiter

Overview:
Two-port round-robin arbiter and sequencer that shares one registered ALU slice between two requesters. The ALU slice is the compare/arith unit with a 1-cycle registered result. Each requester submits {a, b, fun} over a valid/ready handshake. The block issues the operation to the ALU for exactly one cycle, captures the registered result, and returns it to the originating requester over a valid/ready response handshake.

Parameters:
WIDTH_IN, 16, operand width of a/b
WIDTH_OUT, 16, ALU result width
CNT_W, 8, width of completed-operation counter

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req0_valid  in  1  requester 0 has an op
req0_ready  out  1  requester 0 op accepted this cycle when valid&ready
req0_a  in  WIDTH_IN  operand a
req0_b  in  WIDTH_IN  operand b
req0_fun  in  4  ALU function code
req1_valid, req1_ready, req1_a, req1_b, req1_fun: same as requester 0
rsp0_valid  out  1  result for requester 0 available
rsp0_ready  in  1  requester 0 consumes result
rsp1_valid  out  1  result for requester 1 available
rsp1_ready  in  1  requester 1 consumes result
rsp_data  out  WIDTH_OUT  result, shared by both response channels
rsp_flag  out  1  ALU flag, shared
alu_en  out  1  ALU enable, high only in ISSUE
alu_a  out  WIDTH_IN  operand to ALU
alu_b  out  WIDTH_IN  operand to ALU
alu_fun  out  4  function to ALU
alu_result  in  WIDTH_OUT  registered ALU output
alu_flag  in  1  registered ALU flag
busy  out  1  high in any state other than IDLE
grant_id  out  1  requester owning the current op
ops_done  out  CNT_W  count of completed response handshakes, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst high at a clock edge):
  - state=IDLE, last_grant=1 (so requester 0 wins first), grant_id=0.
  - Operand registers, rsp_data, rsp_flag and ops_done cleared to 0.
  - All ready/valid outputs and alu_en are 0 while rst is high.
- Reset mid-operation: in-flight op and pending response are discarded silently; no rsp_valid pulse.
- FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner is combinational: only one valid wins that one; both valid wins the one that is not last_grant.
  - reqN_ready=1 only for the winner, and only in IDLE. The loser's ready stays 0.
  - On valid&ready at edge: capture a/b/fun into registers, grant_id<=N, last_grant<=N, go to ISSUE.
  - Neither valid: stay in IDLE.
- ISSUE (1 cycle): alu_en=1; alu_a/alu_b/alu_fun driven from the captured registers. Next state WAIT.
- WAIT (1 cycle):
  - alu_result/alu_flag are valid this cycle.
  - Capture into rsp_data/rsp_flag at the edge, then go to RESP.
- RESP:
  - rsp{grant_id}_valid=1; the other rsp_valid stays 0.
  - rsp_data/rsp_flag are held stable.
  - On rsp_ready: ops_done++, go to IDLE.
  - Stays in RESP indefinitely while rsp_ready=0.
  - rsp_ready of the non-granted port is ignored.
- Outside ISSUE:
  - alu_en=0.
  - alu_a/alu_b/alu_fun keep the captured register values (no glitching to 0).
- Latency and throughput:
  - Accept at edge E. ISSUE in cycle E+1. rsp_valid first high in cycle E+3.
  - Minimum 4 cycles per op with zero response backpressure.
- Requester valid/operands must stay stable until accepted. The block does not check this.
- The fun code is passed through unchanged. Codes the ALU does not decode still complete normally; result is whatever the ALU returns (0/flag 0 for the compare unit).
- ops_done wraps from 2^CNT_W-1 to 0 with no saturation.
- A new request is never accepted in the same cycle a response completes. IDLE is always visited for at least one cycle.

Test Plan:
1. Reset, then req0 a=5 b=5 fun=4'b1001 alone.
   - req0_ready=1 in the first IDLE cycle and alu_en=1 one cycle later.
   - rsp0_valid rises 3 cycles after accept with rsp_data=1, rsp_flag=1; ops_done=1 after rsp0_ready.
2. Both valid continuously, ops 1 = a=9 b=3 fun=1010 and 2 = a=2 b=7 fun=1011, rsp_ready tied 1.
   - Grants alternate 0,1,0,1.
   - rsp0 returns 2 each time and rsp1 returns 3.
   - Each op takes 4 cycles; rsp1_valid never rises while grant_id=0.
3. Backpressure: hold rsp0_ready=0 for 10 cycles while req1_valid=1.
   - rsp0_valid and rsp_data stay stable.
   - req1_ready stays 0 throughout.
   - Release: req1 is accepted in the cycle after the RESP→IDLE transition.
4. Assert rst in WAIT state.
   - Next cycle all outputs are 0, state IDLE, no rsp_valid pulse.
   - First post-reset request with both valid is granted to req0.
5. Unsupported fun=4'b0000, a=1 b=1.
   - Op completes with rsp_data=0, rsp_flag=0.
   - ops_done still increments.
6. Force ops_done near the top with CNT_W=8 via 256 back-to-back ops.
   - Count wraps 255→0 exactly on the 256th rsp handshake.

Source files
------------

// File: rtl/alu_req_arbiter_if.sv
// Bundle of request, response, ALU-side and status signals for alu_req_arbiter.
// Latency: none (wiring only).
// Backpressure: carries req*_ready / rsp*_ready; the arbiter owns the slave side.
//
// Ports (signals): req0_*/req1_* operand handshakes in, rsp0_*/rsp1_* result
// handshakes out with shared rsp_data/rsp_flag, alu_* to/from the shared ALU
// slice, and busy/grant_id/ops_done status.
interface alu_req_arbiter_if #(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_OUT = 16,
    parameter int CNT_W     = 8
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic [WIDTH_IN-1:0]  req0_a;
    logic [WIDTH_IN-1:0]  req0_b;
    logic [3:0]           req0_fun;

    logic                 req1_valid;
    logic                 req1_ready;
    logic [WIDTH_IN-1:0]  req1_a;
    logic [WIDTH_IN-1:0]  req1_b;
    logic [3:0]           req1_fun;

    logic                 rsp0_valid;
    logic                 rsp0_ready;
    logic                 rsp1_valid;
    logic                 rsp1_ready;
    logic [WIDTH_OUT-1:0] rsp_data;
    logic                 rsp_flag;

    logic                 alu_en;
    logic [WIDTH_IN-1:0]  alu_a;
    logic [WIDTH_IN-1:0]  alu_b;
    logic [3:0]           alu_fun;
    logic [WIDTH_OUT-1:0] alu_result;
    logic                 alu_flag;

    logic                 busy;
    logic                 grant_id;
    logic [CNT_W-1:0]     ops_done;

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_fun,
        input  req1_valid, req1_a, req1_b, req1_fun,
        input  rsp0_ready, rsp1_ready,
        input  alu_result, alu_flag,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_data, rsp_flag,
        output alu_en, alu_a, alu_b, alu_fun,
        output busy, grant_id, ops_done
    );

    // Requester / ALU / environment side.
    modport master (
        output req0_valid, req0_a, req0_b, req0_fun,
        output req1_valid, req1_a, req1_b, req1_fun,
        output rsp0_ready, rsp1_ready,
        output alu_result, alu_flag,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_data, rsp_flag,
        input  alu_en, alu_a, alu_b, alu_fun,
        input  busy, grant_id, ops_done
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered ALU slice between two requesters.
// Latency: accept at edge E, ALU issue in the next cycle, response valid 3 cycles after E; 4 cycles/op minimum.
// Backpressure: holds the response indefinitely until the granted rsp_ready; no new request accepted meanwhile.
//
// Ports: clk, rst (synchronous, active-high); bus (alu_req_arbiter_if.slave)
// carrying both request channels, both response channels, the ALU slice
// interface and the busy/grant_id/ops_done status outputs.
module alu_req_arbiter #(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_OUT = 16,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    alu_req_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic                 last_grant;
    logic                 grant_id_q;
    logic [WIDTH_IN-1:0]  a_q;
    logic [WIDTH_IN-1:0]  b_q;
    logic [3:0]           fun_q;
    logic [WIDTH_OUT-1:0] rsp_data_q;
    logic                 rsp_flag_q;
    logic [CNT_W-1:0]     ops_done_q;

    logic                 any_req;
    logic                 win_id;
    logic                 accept;
    logic                 rsp_sel_ready;
    logic                 rsp_done;

    // Winner selection: a lone requester wins outright; on contention the
    // requester that did not win last time is chosen.
    always_comb begin
        any_req = bus.req0_valid | bus.req1_valid;
        win_id  = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            win_id = ~last_grant;
        end else if (bus.req1_valid) begin
            win_id = 1'b1;
        end
    end

    // Accept only from IDLE, so a completing response (RESP->IDLE) can never
    // coincide with a new acceptance.
    assign accept        = (state == IDLE) && any_req && !rst;
    // The non-granted response ready is deliberately ignored.
    assign rsp_sel_ready = grant_id_q ? bus.rsp1_ready : bus.rsp0_ready;
    assign rsp_done      = (state == RESP) && rsp_sel_ready && !rst;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = RESP;
            RESP:    if (rsp_sel_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers: operand capture, result capture, completion count.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            grant_id_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            fun_q      <= '0;
            rsp_data_q <= '0;
            rsp_flag_q <= 1'b0;
            ops_done_q <= '0;
        end else begin
            if (accept) begin
                grant_id_q <= win_id;
                last_grant <= win_id;
                a_q        <= win_id ? bus.req1_a   : bus.req0_a;
                b_q        <= win_id ? bus.req1_b   : bus.req0_b;
                fun_q      <= win_id ? bus.req1_fun : bus.req0_fun;
            end
            // The ALU registers its result at the end of ISSUE, so it is
            // presented during WAIT and captured here.
            if (state == WAIT) begin
                rsp_data_q <= bus.alu_result;
                rsp_flag_q <= bus.alu_flag;
            end
            if (rsp_done) begin
                ops_done_q <= ops_done_q + CNT_W'(1);
            end
        end
    end

    // Handshake outputs are forced low while reset is asserted, since the
    // state register only clears at the reset edge.
    assign bus.req0_ready = accept && !win_id;
    assign bus.req1_ready = accept &&  win_id;
    assign bus.rsp0_valid = (state == RESP) && !grant_id_q && !rst;
    assign bus.rsp1_valid = (state == RESP) &&  grant_id_q && !rst;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_flag   = rsp_flag_q;

    // Operands are driven from the capture registers at all times so the ALU
    // inputs never glitch; only alu_en qualifies the issue cycle.
    assign bus.alu_en     = (state == ISSUE) && !rst;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_fun    = fun_q;

    assign bus.busy       = (state != IDLE);
    assign bus.grant_id   = grant_id_q;
    assign bus.ops_done   = ops_done_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a behavioural registered ALU slice.
// Latency: checks the 4-cycle op sequence and 3-cycle accept-to-response timing.
// Backpressure: holds rsp_ready low to verify stable response and blocked requests.
module tb_alu_req_arbiter;

    localparam int WIDTH_IN  = 16;
    localparam int WIDTH_OUT = 16;
    localparam int CNT_W     = 8;

    logic clk;
    logic rst;

    int n_tests = 0;
    int n_fail  = 0;

    alu_req_arbiter_if #(.WIDTH_IN(WIDTH_IN), .WIDTH_OUT(WIDTH_OUT), .CNT_W(CNT_W)) bus ();

    alu_req_arbiter #(.WIDTH_IN(WIDTH_IN), .WIDTH_OUT(WIDTH_OUT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU slice, result registered on the issue cycle:
    //   1001: equality -> result/flag = (a == b)
    //   1010: a > b    -> result 2, flag 1, else 0/0
    //   1011: a < b    -> result 3, flag 1, else 0/0
    //   other codes    -> 0/0
    always @(posedge clk) begin
        if (rst) begin
            bus.alu_result <= '0;
            bus.alu_flag   <= 1'b0;
        end else if (bus.alu_en) begin
            case (bus.alu_fun)
                4'b1001: begin
                    bus.alu_result <= (bus.alu_a == bus.alu_b) ? 16'd1 : 16'd0;
                    bus.alu_flag   <= (bus.alu_a == bus.alu_b);
                end
                4'b1010: begin
                    bus.alu_result <= (bus.alu_a > bus.alu_b) ? 16'd2 : 16'd0;
                    bus.alu_flag   <= (bus.alu_a > bus.alu_b);
                end
                4'b1011: begin
                    bus.alu_result <= (bus.alu_a < bus.alu_b) ? 16'd3 : 16'd0;
                    bus.alu_flag   <= (bus.alu_a < bus.alu_b);
                end
                default: begin
                    bus.alu_result <= '0;
                    bus.alu_flag   <= 1'b0;
                end
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic set_req0(input logic v, input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
        bus.req0_valid = v;
        bus.req0_a     = a;
        bus.req0_b     = b;
        bus.req0_fun   = f;
    endtask

    task automatic set_req1(input logic v, input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
        bus.req1_valid = v;
        bus.req1_a     = a;
        bus.req1_b     = b;
        bus.req1_fun   = f;
    endtask

    // One complete op on requester 0 with bounded waits on ready and response.
    task automatic run_op0();
        bit seen;
        set_req0(1'b1, 16'd4, 16'd4, 4'b1001);
        #1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!seen) begin
                if (bus.req0_ready === 1'b1) seen = 1'b1;
                else step();
            end
        end
        check("op_accept", {31'd0, seen}, 32'd1);
        step();
        bus.req0_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!seen) begin
                if (bus.rsp0_valid === 1'b1) seen = 1'b1;
                else step();
            end
        end
        check("op_rsp", {31'd0, seen}, 32'd1);
        bus.rsp0_ready = 1'b1;
        step();
        bus.rsp0_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit g;
        rst = 1'b1;
        set_req0(1'b0, '0, '0, '0);
        set_req1(1'b0, '0, '0, '0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;

        // ---- 1: reset state, then single op on requester 0 ----
        set_req0(1'b1, 16'd5, 16'd5, 4'b1001);
        step();
        step();
        check("rst_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
        check("rst_alu_en",     {31'd0, bus.alu_en},     32'd0);
        check("rst_busy",       {31'd0, bus.busy},       32'd0);
        check("rst_grant",      {31'd0, bus.grant_id},   32'd0);
        check("rst_ops",        {24'd0, bus.ops_done},   32'd0);
        check("rst_rsp_data",   {16'd0, bus.rsp_data},   32'd0);
        check("rst_alu_a",      {16'd0, bus.alu_a},      32'd0);
        rst = 1'b0;
        #1;
        check("t1_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
        check("t1_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
        step();
        check("t1_alu_en",  {31'd0, bus.alu_en},  32'd1);
        check("t1_alu_a",   {16'd0, bus.alu_a},   32'd5);
        check("t1_alu_b",   {16'd0, bus.alu_b},   32'd5);
        check("t1_alu_fun", {28'd0, bus.alu_fun}, 32'h9);
        check("t1_busy",    {31'd0, bus.busy},    32'd1);
        bus.req0_valid = 1'b0;
        step();
        check("t1_wait_alu_en", {31'd0, bus.alu_en},     32'd0);
        check("t1_wait_alu_a",  {16'd0, bus.alu_a},      32'd5);
        check("t1_wait_rsp0",   {31'd0, bus.rsp0_valid}, 32'd0);
        step();
        check("t1_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd1);
        check("t1_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
        check("t1_rsp_data",   {16'd0, bus.rsp_data},   32'd1);
        check("t1_rsp_flag",   {31'd0, bus.rsp_flag},   32'd1);
        bus.rsp0_ready = 1'b1;
        step();
        bus.rsp0_ready = 1'b0;
        check("t1_ops_done", {24'd0, bus.ops_done}, 32'd1);
        check("t1_idle",     {31'd0, bus.busy},     32'd0);

        // ---- 2: both requesting continuously, alternating grants ----
        do_reset();
        set_req0(1'b1, 16'd9, 16'd3, 4'b1010);
        set_req1(1'b1, 16'd2, 16'd7, 4'b1011);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            g = k[0];
            check("t2_ready_win",  {31'd0, g ? bus.req1_ready : bus.req0_ready}, 32'd1);
            check("t2_ready_lose", {31'd0, g ? bus.req0_ready : bus.req1_ready}, 32'd0);
            step();
            check("t2_grant",  {31'd0, bus.grant_id}, {31'd0, g});
            check("t2_alu_en", {31'd0, bus.alu_en},   32'd1);
            step();
            check("t2_wait_rsp1", {31'd0, bus.rsp1_valid}, 32'd0);
            step();
            check("t2_rsp0_valid", {31'd0, bus.rsp0_valid}, {31'd0, ~g});
            check("t2_rsp1_valid", {31'd0, bus.rsp1_valid}, {31'd0, g});
            check("t2_rsp_data",   {16'd0, bus.rsp_data},   g ? 32'd3 : 32'd2);
            if (k == 3) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
            step();
        end
        check("t2_ops_done", {24'd0, bus.ops_done}, 32'd4);
        check("t2_idle",     {31'd0, bus.busy},     32'd0);

        // ---- 3: response backpressure on requester 0 ----
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        bus.req0_valid = 1'b1;
        #1;
        check("t3_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1;
        step();
        step();
        bus.rsp1_ready = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            check("t3_hold_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd1);
            check("t3_hold_rsp_data",   {16'd0, bus.rsp_data},   32'd2);
            check("t3_hold_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
            step();
        end
        bus.rsp0_ready = 1'b1;
        #1;
        check("t3_release_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
        step();
        bus.rsp0_ready = 1'b0;
        check("t3_idle",        {31'd0, bus.busy},       32'd0);
        check("t3_req1_ready",  {31'd0, bus.req1_ready}, 32'd1);
        check("t3_ops_done",    {24'd0, bus.ops_done},   32'd5);
        step();
        check("t3_grant1",  {31'd0, bus.grant_id}, 32'd1);
        check("t3_alu_a",   {16'd0, bus.alu_a},    32'd2);
        bus.req1_valid = 1'b0;
        step();
        step();
        check("t3_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd1);
        check("t3_rsp1_data",  {16'd0, bus.rsp_data},   32'd3);
        step();
        bus.rsp1_ready = 1'b0;
        check("t3_ops_done2", {24'd0, bus.ops_done}, 32'd6);

        // ---- 4: reset while in WAIT ----
        set_req0(1'b1, 16'd5, 16'd5, 4'b1001);
        #1;
        step();
        bus.req0_valid = 1'b0;
        step();
        check("t4_busy_wait", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("t4_busy",      {31'd0, bus.busy},       32'd0);
        check("t4_rsp0",      {31'd0, bus.rsp0_valid}, 32'd0);
        check("t4_rsp1",      {31'd0, bus.rsp1_valid}, 32'd0);
        check("t4_rsp_data",  {16'd0, bus.rsp_data},   32'd0);
        check("t4_rsp_flag",  {31'd0, bus.rsp_flag},   32'd0);
        check("t4_ops_done",  {24'd0, bus.ops_done},   32'd0);
        check("t4_alu_a",     {16'd0, bus.alu_a},      32'd0);
        check("t4_alu_en",    {31'd0, bus.alu_en},     32'd0);
        check("t4_grant",     {31'd0, bus.grant_id},   32'd0);
        set_req0(1'b1, 16'd5, 16'd5, 4'b1001);
        set_req1(1'b1, 16'd1, 16'd1, 4'b0000);
        #1;
        check("t4_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
        check("t4_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check("t4_grant0", {31'd0, bus.grant_id}, 32'd0);
        step();
        step();
        check("t4_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd1);
        check("t4_rsp_data1",  {16'd0, bus.rsp_data},   32'd1);
        bus.rsp0_ready = 1'b1;
        step();
        bus.rsp0_ready = 1'b0;
        check("t4_ops_done1", {24'd0, bus.ops_done}, 32'd1);

        // ---- 5: unsupported function code ----
        set_req1(1'b1, 16'd1, 16'd1, 4'b0000);
        #1;
        check("t5_req1_ready", {31'd0, bus.req1_ready}, 32'd1);
        step();
        bus.req1_valid = 1'b0;
        check("t5_alu_fun", {28'd0, bus.alu_fun}, 32'd0);
        step();
        step();
        check("t5_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd1);
        check("t5_rsp_data",   {16'd0, bus.rsp_data},   32'd0);
        check("t5_rsp_flag",   {31'd0, bus.rsp_flag},   32'd0);
        bus.rsp1_ready = 1'b1;
        step();
        bus.rsp1_ready = 1'b0;
        check("t5_ops_done", {24'd0, bus.ops_done}, 32'd2);

        // ---- 6: ops_done wrap after 256 handshakes ----
        do_reset();
        for (int i = 0; i < 255; i++) begin
            run_op0();
        end
        check("t6_ops_255", {24'd0, bus.ops_done}, 32'd255);
        run_op0();
        check("t6_ops_wrap", {24'd0, bus.ops_done}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
